// File: rtl/adder_tree_feeder_pkg.sv
// Shared definitions for the adder tree feeder: lane width, index sizing, FSM states.
package adder_tree_feeder_pkg;

    localparam int LANE_W = 32;

    // Bits needed to address n lanes; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/adder_tree_feeder.sv
// Packs a serial valid/ready word stream into an N-lane vector for the adder tree.
// Latency: vector valid the cycle after its last word is accepted.
// Backpressure: vector held stable until out_ready; in_ready low while holding (one bubble per group).
module adder_tree_feeder
    import adder_tree_feeder_pkg::*;
#(
    parameter int N = 16,
    parameter int W = LANE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*W-1:0]          out_vec,
    output logic [$clog2(N+1)-1:0]  out_count
);

    localparam int IDX_W = idx_w(N);
    localparam int CNT_W = $clog2(N+1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [N*W-1:0]   vec_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic close_grp;
    logic release_vec;

    assign accept      = in_valid && (state_q == FILL);
    assign close_grp   = accept && (in_last || (idx_q == IDX_W'(N - 1)));
    assign release_vec = (state_q == HOLD) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close_grp)   state_d = HOLD;
            HOLD:    if (release_vec) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Clearing the vector on release means unwritten lanes of the next group read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            vec_q <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        vec_q[i*W +: W] <= in_data;
                    end
                end
                if (close_grp) begin
                    idx_q <= '0;
                    cnt_q <= CNT_W'(idx_q) + CNT_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (release_vec) begin
                vec_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_vec   = vec_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench: directed N=4 vector table plus corner sequences, and an N=16 random stream vs a scoreboard.
module tb_adder_tree_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4 instance for the directed tests
    logic         in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0]  in_data;
    logic [127:0] out_vec;
    logic [2:0]   out_count;

    // N=16 instance for the random stream
    logic         r_in_valid, r_in_ready, r_in_last, r_out_valid, r_out_ready;
    logic [31:0]  r_in_data;
    logic [511:0] r_out_vec;
    logic [4:0]   r_out_count;

    adder_tree_feeder #(.N(4), .W(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_count(out_count)
    );

    adder_tree_feeder #(.N(16), .W(32)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data), .in_last(r_in_last),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_vec(r_out_vec), .out_count(r_out_count)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [33:0] lane_sum(input logic [127:0] v);
        logic [33:0] s = '0;
        for (int k = 0; k < 4; k++) s += {2'b00, v[k*32 +: 32]};
        return s;
    endfunction

    typedef struct {
        logic [3:0][31:0] w;     // w[k] is the k-th word sent
        int               n;
        bit               last;  // in_last on the final word
        logic [127:0]     vec;
        int               cnt;
    } vec_t;

    vec_t tbl [6];

    // Drives n words back-to-back; returns #1 after the edge that accepts the last one.
    task automatic send(input logic [3:0][31:0] w, input int n, input bit last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            in_last  = last && (k == n - 1);
            chk("fill_in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (k < n - 1) chk("fill_no_early_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    typedef struct {
        logic [511:0] vec;
        int           cnt;
    } exp_t;

    initial begin
        logic [33:0]  exp_sum;
        logic [31:0]  grp[$];
        exp_t         expq[$];
        exp_t         e;
        int           sent, got, cyc;
        bit           hold_prev;
        logic [511:0] vec_prev;
        logic [4:0]   cnt_prev;

        tbl[0] = '{w: {32'd4, 32'd3, 32'd2, 32'd1}, n: 4, last: 1'b0,
                   vec: {32'd4, 32'd3, 32'd2, 32'd1}, cnt: 4};
        tbl[1] = '{w: {32'd0, 32'd0, 32'd9, 32'd7}, n: 2, last: 1'b1,
                   vec: {32'd0, 32'd0, 32'd9, 32'd7}, cnt: 2};
        tbl[2] = '{w: {32'd1, 32'd1, 32'd1, 32'd1}, n: 4, last: 1'b0,
                   vec: {32'd1, 32'd1, 32'd1, 32'd1}, cnt: 4};
        tbl[3] = '{w: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, n: 1, last: 1'b1,
                   vec: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, cnt: 1};
        tbl[4] = '{w: {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001}, n: 4, last: 1'b1,
                   vec: {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001}, cnt: 4};
        tbl[5] = '{w: {32'd0, 32'h30, 32'h20, 32'h10}, n: 3, last: 1'b1,
                   vec: {32'd0, 32'h30, 32'h20, 32'h10}, cnt: 3};

        rst = 1'b1;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        r_in_valid = 0; r_in_data = '0; r_in_last = 0; r_out_ready = 0;

        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_vec", out_vec, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Table: groups sent back-to-back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].w, tbl[i].n, tbl[i].last);
            exp_sum = '0;
            for (int k = 0; k < tbl[i].n; k++) exp_sum += {2'b00, tbl[i].w[k]};
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_out_vec", out_vec, tbl[i].vec);
            chk("tbl_out_count", out_count, tbl[i].cnt);
            chk("tbl_tree_sum", lane_sum(out_vec), exp_sum);
            chk("tbl_bubble_in_ready", in_ready, 0);
            @(posedge clk); #1;
            chk("tbl_release_valid", out_valid, 0);
            chk("tbl_release_in_ready", in_ready, 1);
            chk("tbl_release_vec", out_vec, 0);
        end

        // Backpressure: hold for 5 cycles while stray input pulses arrive
        out_ready = 1'b0;
        send({32'd4, 32'd3, 32'd2, 32'd1}, 4, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_vec", out_vec, {32'd4, 32'd3, 32'd2, 32'd1});
            chk("bp_out_count", out_count, 4);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        chk("bp_still_valid", out_valid, 1);
        @(posedge clk); #1;
        chk("bp_accepted", out_valid, 0);
        chk("bp_cleared", out_vec, 0);
        send({32'd2, 32'd2, 32'd2, 32'd2}, 4, 1'b0);
        chk("bp_next_vec", out_vec, {32'd2, 32'd2, 32'd2, 32'd2});
        chk("bp_next_count", out_count, 4);
        @(posedge clk); #1;

        // Async reset in the middle of a group
        in_valid = 1'b1; in_data = 32'hA;
        @(posedge clk); #1;
        in_data = 32'hB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vec", out_vec, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset while holding a complete vector
        out_ready = 1'b0;
        send({32'd4, 32'd3, 32'd2, 32'd1}, 4, 1'b0);
        chk("hold_before_rst", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("hold_rst_valid", out_valid, 0);
        chk("hold_rst_vec", out_vec, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send({32'd8, 32'd7, 32'd6, 32'd5}, 4, 1'b0);
        chk("post_rst_vec", out_vec, {32'd8, 32'd7, 32'd6, 32'd5});
        chk("post_rst_count", out_count, 4);
        @(posedge clk); #1;

        // Random N=16 stream, scoreboard built from accepted words
        sent = 0; got = 0; cyc = 0; hold_prev = 0;
        vec_prev = '0; cnt_prev = '0;
        while (got < 4 && cyc < 4000) begin
            r_in_valid  = (sent < 64) && ($urandom_range(0, 3) != 0);
            r_in_data   = $urandom;
            r_in_last   = 1'b0;
            r_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_prev) begin
                chk("rnd_hold_valid", r_out_valid, 1);
                chk("rnd_hold_vec", r_out_vec, vec_prev);
                chk("rnd_hold_count", r_out_count, cnt_prev);
            end
            chk("rnd_no_overlap", r_in_ready && r_out_valid, 0);
            if (r_in_valid && r_in_ready) begin
                grp.push_back(r_in_data);
                sent++;
                if (grp.size() == 16) begin
                    e.vec = '0;
                    for (int k = 0; k < 16; k++) e.vec[k*32 +: 32] = grp[k];
                    e.cnt = 16;
                    expq.push_back(e);
                    grp.delete();
                end
            end
            if (r_out_valid && r_out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL rnd_spurious: vector %0h with no complete group pending", r_out_vec);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_vec", r_out_vec, e.vec);
                    chk("rnd_count", r_out_count, e.cnt);
                end
                got++;
            end
            hold_prev = r_out_valid && !r_out_ready;
            vec_prev  = r_out_vec;
            cnt_prev  = r_out_count;
            @(posedge clk); #1;
            cyc++;
        end
        r_in_valid = 1'b0; r_out_ready = 1'b0;
        chk("rnd_vectors", got, 4);
        chk("rnd_words", sent, 64);
        chk("rnd_leftover", grp.size() + expq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
